pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. The WIDTH-bit operands are split into GROUP-bit lookahead groups. Each pipeline stage resolves one group and registers its carry-out into the next stage. The block serves as the arithmetic datapath unit for wide operands, where a single-cycle ripple or flat CLA misses timing.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of GROUP.
GROUP, 8, bits per lookahead group, and therefore per pipeline stage; GROUP >= 2.
NUM_GROUPS, WIDTH/GROUP, derived; number of stages and the latency in cycles; not to be overridden.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  operands valid
ready_o  output  1  block accepts operands this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
c_i  input  1  carry-in
sub_i  input  1  1 = subtract mode
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
o_o  output  WIDTH  sum/difference
c_o  output  1  carry-out of MSB
ovf_o  output  1  two's-complement signed overflow

Behaviour:
- Clocking and reset:
  - One clock domain, clk_i.
  - rst_ni is asynchronous active-low, released synchronously outside the block.
- Arithmetic:
  - Effective operand is B' = b_i XOR {WIDTH{sub_i}}.
  - Effective carry-in is c_i XOR sub_i.
  - o_o = (a_i + B' + cin) mod 2^WIDTH.
  - c_o = bit WIDTH of that sum, so in subtract mode c_o = 1 means no borrow.
  - ovf_o = (a[MSB] == B'[MSB]) && (o[MSB] != a[MSB]).
- Pipeline structure:
  - Stage k (0..NUM_GROUPS-1) feeds group k of A and B' plus the registered carry from stage k-1 (stage 0 uses cin) into one combinational CLA group.
  - Stage k registers the group sum bits, the group carry-out, the not-yet-consumed upper operand groups (input skew) and the already-produced lower sum groups (output deskew).
  - a[MSB] and B'[MSB] travel with the data for the ovf_o calculation.
- Stage validity:
  - Each stage holds a valid bit; valid_o is the valid bit of the last stage.
- Flow control:
  - Global advance enable: en = !valid_o || ready_i.
  - ready_o = en, combinational from valid_o and ready_i only; it never depends on valid_i.
  - When en = 1, every stage loads from its predecessor, and stage 0 loads valid_i plus the operands.
  - When en = 0, all registers hold. o_o, c_o and ovf_o must stay stable while valid_o && !ready_i.
- Transfer rules:
  - An input transfer occurs on valid_i && ready_o.
  - An output transfer occurs on valid_o && ready_i.
- Latency and throughput:
  - Latency is exactly NUM_GROUPS cycles from input transfer to valid_o, with no stalls.
  - Throughput is one result per cycle.
  - Bubbles (valid_i = 0) propagate as invalid stages. Data registers may still load on a bubble; outputs are don't-care while valid_o = 0.
- Reset values:
  - All valid bits are 0, so valid_o = 0.
  - o_o = 0, c_o = 0, ovf_o = 0.
  - All data and carry registers are 0.
  - ready_o = 1 immediately after reset.
- Boundary conditions:
  - Reset mid-operation flushes every in-flight result; none is emitted after release.
  - NUM_GROUPS = 1 gives a single registered stage with latency 1.
  - Full carry propagation across all groups (e.g. 0 + all-ones + 1) must be correct.
  - Simultaneous output drain and input accept on a full pipeline proceeds without a bubble.
- Elaboration checks:
  - Assert WIDTH % GROUP == 0 and GROUP >= 2.
- Simulation assertions:
  - No valid_o drop while !ready_i.
  - Outputs stable under stall.

Decomposition:
- Package cla_pkg:
  - Function computing group generate/propagate.
  - Typedef for the per-stage carry/valid record (valid, carry, a_msb, b_msb).
- Sub-module cla_group (parameter GROUP):
  - Purely combinational.
  - Ports: a_i, b_i, c_i, o_o, c_o, plus group generate/propagate outputs g_o and p_o.
  - Instantiated NUM_GROUPS times via generate.
- Top level holds the skew/deskew registers, valid chain and handshake.

Test Plan:
- WIDTH=8, GROUP=4, ready_i=1, one item per scenario; latency is 2 cycles.
  - a=0x06, b=0x06, c_i=0, sub_i=0 -> o_o=0x0C, c_o=0, ovf_o=0.
  - a=0x06, b=0x06, c_i=1 -> o_o=0x0D.
  - a=0x80, b=0x80, c_i=0 -> o_o=0x00, c_o=1, ovf_o=1.
  - a=0x80, b=0x80, c_i=1 -> o_o=0x01, c_o=1, ovf_o=1.
  - a=0x00, b=0xFF, c_i=1 -> o_o=0x00, c_o=1, ovf_o=0.
- Subtract mode, WIDTH=8, GROUP=4:
  - a=0x05, b=0x07, sub_i=1, c_i=0 -> o_o=0xFE, c_o=0, ovf_o=0.
  - a=0x80, b=0x01, sub_i=1 -> o_o=0x7F, c_o=1, ovf_o=1.
- Backpressure, WIDTH=8, GROUP=4: stream 4 back-to-back items with ready_i=0 for cycles 3..5.
  - ready_o=0 while valid_o=1 and ready_i=0.
  - o_o holds its value unchanged throughout the stall.
  - All 4 results emerge in order, none lost or duplicated.
- Reset mid-operation: assert rst_ni=0 with 2 items in flight.
  - valid_o=0 and o_o=0 immediately (asynchronously).
  - No result appears after release until a new input is accepted.
- Random regression, WIDTH=32, GROUP=8: 10k random a/b/c_i/sub_i with random valid_i and ready_i.
  - Scoreboard against a behavioural model matches every result.
  - Latency is exactly 4 cycles whenever there is no stall.
- Degenerate configuration, WIDTH=16, GROUP=16:
  - Latency is 1 cycle.
  - 0xFFFF + 0x0001 -> o_o=0x0000, c_o=1.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and group lookahead helper for the pipelined CLA adder
package cla_pkg;

   localparam int unsigned MAX_GROUP = 64;

   typedef struct packed {
      logic valid;
      logic carry;
      logic a_msb;
      logic b_msb;
   } cla_stage_t;

   // Group generate/propagate over the lowest n bits of g/p.
   function automatic logic [1:0] group_gp(input logic [MAX_GROUP-1:0] g,
                                           input logic [MAX_GROUP-1:0] p,
                                           input int unsigned n);
      logic gg;
      logic pp;
      gg = 1'b0;
      pp = 1'b1;
      for (int unsigned i = 0; i < MAX_GROUP; i++) begin
         if (i < n) begin
            gg = g[i] | (p[i] & gg);
            pp = pp & p[i];
         end
      end
      return {gg, pp};
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead adder slice
module cla_group
   import cla_pkg::*;
#(
   parameter int unsigned GROUP = 8
) (
   input  logic [GROUP-1:0] a_i,
   input  logic [GROUP-1:0] b_i,
   input  logic             c_i,
   output logic [GROUP-1:0] o_o,
   output logic             c_o,
   output logic             g_o,
   output logic             p_o
);

   logic [GROUP-1:0]     gen;
   logic [GROUP-1:0]     prp;
   logic [GROUP:0]       carry;
   logic [MAX_GROUP-1:0] gen_ext;
   logic [MAX_GROUP-1:0] prp_ext;
   logic [1:0]           gp_pre;
   logic [1:0]           gp_all;

   assign gen     = a_i & b_i;
   assign prp     = a_i ^ b_i;
   assign gen_ext = MAX_GROUP'(gen);
   assign prp_ext = MAX_GROUP'(prp);

   // Every bit carry is a flat prefix term of the group inputs, not a ripple.
   always_comb begin
      carry    = '0;
      gp_pre   = '0;
      carry[0] = c_i;
      for (int unsigned i = 0; i < GROUP; i++) begin
         gp_pre     = group_gp(gen_ext, prp_ext, i + 1);
         carry[i+1] = gp_pre[1] | (gp_pre[0] & c_i);
      end
   end

   assign gp_all = group_gp(gen_ext, prp_ext, GROUP);
   assign g_o    = gp_all[1];
   assign p_o    = gp_all[0];
   assign o_o    = prp ^ carry[GROUP-1:0];
   assign c_o    = carry[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - valid/ready pipelined CLA adder/subtractor, one group per stage
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned GROUP = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   input  logic             sub_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] o_o,
   output logic             c_o,
   output logic             ovf_o
);

   localparam int unsigned NUM_GROUPS = WIDTH / GROUP;
   localparam int unsigned LAST       = NUM_GROUPS - 1;

   if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > MAX_GROUP) begin : g_bad_params
      $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, 2 <= GROUP <= MAX_GROUP");
   end

   logic                  en;
   logic [WIDTH-1:0]      b_eff;
   // acc words: already-summed groups below the stage, raw A groups above it.
   logic [WIDTH-1:0]      acc_in [NUM_GROUPS];
   logic [WIDTH-1:0]      acc_d  [NUM_GROUPS];
   logic [WIDTH-1:0]      acc_q  [NUM_GROUPS];
   logic [WIDTH-1:0]      bop_in [NUM_GROUPS];
   logic [WIDTH-1:0]      bop_q  [NUM_GROUPS];
   cla_stage_t            ctl_in [NUM_GROUPS];
   cla_stage_t            ctl_d  [NUM_GROUPS];
   cla_stage_t            ctl_q  [NUM_GROUPS];
   logic [GROUP-1:0]      grp_sum [NUM_GROUPS];
   logic [NUM_GROUPS-1:0] grp_c;
   logic [NUM_GROUPS-1:0] grp_g;
   logic [NUM_GROUPS-1:0] grp_p;
   logic [NUM_GROUPS-1:0] grp_cin;

   assign en      = !valid_o || ready_i;
   assign ready_o = en;
   assign b_eff   = b_i ^ {WIDTH{sub_i}};

   always_comb begin
      acc_in[0] = a_i;
      bop_in[0] = b_eff;
      ctl_in[0] = '{valid: valid_i, carry: c_i ^ sub_i, a_msb: a_i[WIDTH-1], b_msb: b_eff[WIDTH-1]};
      for (int unsigned k = 1; k < NUM_GROUPS; k++) begin
         acc_in[k] = acc_q[k-1];
         bop_in[k] = bop_q[k-1];
         ctl_in[k] = ctl_q[k-1];
      end
   end

   for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
      cla_group #(.GROUP(GROUP)) u_grp (
         .a_i (acc_in[k][k*GROUP +: GROUP]),
         .b_i (bop_in[k][k*GROUP +: GROUP]),
         .c_i (ctl_in[k].carry),
         .o_o (grp_sum[k]),
         .c_o (grp_c[k]),
         .g_o (grp_g[k]),
         .p_o (grp_p[k])
      );
   end

   always_comb begin
      grp_cin = '0;
      for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
         acc_d[k]                    = acc_in[k];
         acc_d[k][k*GROUP +: GROUP]  = grp_sum[k];
         ctl_d[k]                    = ctl_in[k];
         ctl_d[k].carry              = grp_c[k];
         grp_cin[k]                  = ctl_in[k].carry;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
            acc_q[k] <= '0;
            bop_q[k] <= '0;
            ctl_q[k] <= '0;
         end
      end else if (en) begin
         for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
            acc_q[k] <= acc_d[k];
            bop_q[k] <= bop_in[k];
            ctl_q[k] <= ctl_d[k];
         end
      end
   end

   assign valid_o = ctl_q[LAST].valid;
   assign o_o     = acc_q[LAST];
   assign c_o     = ctl_q[LAST].carry;
   assign ovf_o   = (ctl_q[LAST].a_msb == ctl_q[LAST].b_msb) && (o_o[WIDTH-1] != ctl_q[LAST].a_msb);

   a_group_lookahead: assert property (@(posedge clk_i) grp_c == (grp_g | (grp_p & grp_cin)));
   a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_o && !ready_i |=> valid_o);
   a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_o && !ready_i |=> $stable(o_o) && $stable(c_o) && $stable(ovf_o));

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed and scoreboard bench for pipelined_cla_adder
module tb_pipelined_cla_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        v8_i, r8_i, ro8, vo8, c8, s8, co8, ovf8;
   logic [7:0]  a8, b8, o8;
   logic        v32_i, r32_i, ro32, vo32, c32, s32, co32, ovf32;
   logic [31:0] a32, b32, o32;
   logic        v16_i, r16_i, ro16, vo16, c16, s16, co16, ovf16;
   logic [15:0] a16, b16, o16;

   pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v8_i), .ready_o(ro8), .a_i(a8), .b_i(b8),
      .c_i(c8), .sub_i(s8), .valid_o(vo8), .ready_i(r8_i), .o_o(o8), .c_o(co8), .ovf_o(ovf8));
   pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v32_i), .ready_o(ro32), .a_i(a32), .b_i(b32),
      .c_i(c32), .sub_i(s32), .valid_o(vo32), .ready_i(r32_i), .o_o(o32), .c_o(co32), .ovf_o(ovf32));
   pipelined_cla_adder #(.WIDTH(16), .GROUP(16)) u_dut16 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v16_i), .ready_o(ro16), .a_i(a16), .b_i(b16),
      .c_i(c16), .sub_i(s16), .valid_o(vo16), .ready_i(r16_i), .o_o(o16), .c_o(co16), .ovf_o(ovf16));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       sub;
      logic [7:0] o;
      logic       co;
      logic       ovf;
   } vec8_t;

   typedef struct packed {
      logic [33:0] exp;
      int          cyc;
      int          st;
   } sb_t;

   task automatic run8(input vec8_t v, input string tag);
      int lat;
      @(posedge clk); #1;
      a8 = v.a; b8 = v.b; c8 = v.c; s8 = v.sub; v8_i = 1'b1; r8_i = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         v8_i = 1'b0;
         lat++;
      end while (!vo8 && lat < 10);
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_o"}, o8, v.o);
      chk({tag, "_c"}, co8, v.co);
      chk({tag, "_ovf"}, ovf8, v.ovf);
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] eo, input logic ec, input string tag);
      int lat;
      @(posedge clk); #1;
      a16 = a; b16 = b; c16 = c; s16 = s; v16_i = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         v16_i = 1'b0;
         lat++;
      end while (!vo16 && lat < 10);
      chk({tag, "_lat"}, lat, 1);
      chk({tag, "_o"}, o16, eo);
      chk({tag, "_c"}, co16, ec);
   endtask

   vec8_t vecs [9];
   logic [7:0] bp_a [4];
   logic [7:0] bp_b [4];
   logic [7:0] bp_exp [4];
   logic [7:0] got_o [$];
   int         got_cyc [$];
   sb_t        sb [$];

   initial begin
      int idx, stall_seen, n, stalls, cyc;
      logic [31:0] bprime;
      logic [32:0] sum;
      logic        ovf;
      sb_t         ent;

      vecs[0] = '{a: 8'h06, b: 8'h06, c: 1'b0, sub: 1'b0, o: 8'h0C, co: 1'b0, ovf: 1'b0};
      vecs[1] = '{a: 8'h06, b: 8'h06, c: 1'b1, sub: 1'b0, o: 8'h0D, co: 1'b0, ovf: 1'b0};
      vecs[2] = '{a: 8'h80, b: 8'h80, c: 1'b0, sub: 1'b0, o: 8'h00, co: 1'b1, ovf: 1'b1};
      vecs[3] = '{a: 8'h80, b: 8'h80, c: 1'b1, sub: 1'b0, o: 8'h01, co: 1'b1, ovf: 1'b1};
      vecs[4] = '{a: 8'h00, b: 8'hFF, c: 1'b1, sub: 1'b0, o: 8'h00, co: 1'b1, ovf: 1'b0};
      vecs[5] = '{a: 8'h05, b: 8'h07, c: 1'b0, sub: 1'b1, o: 8'hFE, co: 1'b0, ovf: 1'b0};
      vecs[6] = '{a: 8'h80, b: 8'h01, c: 1'b0, sub: 1'b1, o: 8'h7F, co: 1'b1, ovf: 1'b1};
      vecs[7] = '{a: 8'h7F, b: 8'h01, c: 1'b0, sub: 1'b0, o: 8'h80, co: 1'b0, ovf: 1'b1};
      vecs[8] = '{a: 8'h0F, b: 8'h01, c: 1'b0, sub: 1'b0, o: 8'h10, co: 1'b0, ovf: 1'b0};
      bp_a[0] = 8'h11; bp_b[0] = 8'h22; bp_exp[0] = 8'h33;
      bp_a[1] = 8'hF0; bp_b[1] = 8'h0F; bp_exp[1] = 8'hFF;
      bp_a[2] = 8'h7F; bp_b[2] = 8'h7F; bp_exp[2] = 8'hFE;
      bp_a[3] = 8'h99; bp_b[3] = 8'h01; bp_exp[3] = 8'h9A;

      rst_n = 1'b0;
      v8_i = 0; r8_i = 1; a8 = 0; b8 = 0; c8 = 0; s8 = 0;
      v32_i = 0; r32_i = 1; a32 = 0; b32 = 0; c32 = 0; s32 = 0;
      v16_i = 0; r16_i = 1; a16 = 0; b16 = 0; c16 = 0; s16 = 0;
      #2;
      chk("rst_valid8", vo8, 0);
      chk("rst_o8", o8, 0);
      chk("rst_c8", co8, 0);
      chk("rst_ovf8", ovf8, 0);
      chk("rst_ready8", ro8, 1);
      chk("rst_valid32", vo32, 0);
      chk("rst_valid16", vo16, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run8(vecs[i], $sformatf("vec%0d", i));

      // Four back-to-back items, downstream stalled in cycles 3..5.
      idx = 0; stall_seen = 0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         r8_i = !(c >= 3 && c <= 5);
         v8_i = (idx < 4);
         if (idx < 4) begin a8 = bp_a[idx]; b8 = bp_b[idx]; c8 = 0; s8 = 0; end
         @(negedge clk);
         if (vo8 && !r8_i) begin
            stall_seen++;
            chk("bp_ready_low", ro8, 0);
            chk("bp_hold_o", o8, bp_exp[0]);
         end
         if (vo8 && r8_i) begin got_o.push_back(o8); got_cyc.push_back(c); end
         if (v8_i && ro8) idx++;
      end
      v8_i = 0; r8_i = 1;
      chk("bp_stall_cycles", stall_seen, 3);
      chk("bp_count", got_o.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_o.size()) begin
            chk($sformatf("bp_data%0d", i), got_o[i], bp_exp[i]);
            chk($sformatf("bp_cycle%0d", i), got_cyc[i], 6 + i);
         end
      end

      // Reset with two items in flight.
      @(posedge clk); #1;
      a8 = 8'h01; b8 = 8'h02; c8 = 0; s8 = 0; v8_i = 1;
      @(posedge clk); #1;
      a8 = 8'h03; b8 = 8'h04;
      @(posedge clk); #1;
      v8_i = 0;
      chk("mid_pre_valid", vo8, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", vo8, 0);
      chk("mid_rst_o", o8, 0);
      chk("mid_rst_c", co8, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (vo8) n++;
      end
      chk("mid_no_ghost", n, 0);
      run8(vecs[2], "post_rst");

      // Random regression on the 32/8 configuration.
      stalls = 0;
      for (cyc = 0; cyc < 10000; cyc++) begin
         @(posedge clk); #1;
         v32_i = ($urandom_range(0, 9) < 7);
         r32_i = ($urandom_range(0, 3) != 0);
         a32 = $urandom; b32 = $urandom;
         c32 = 1'($urandom_range(0, 1)); s32 = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!ro32) stalls++;
         if (vo32 && r32_i) begin
            if (sb.size() == 0) chk("rnd_unexpected_out", 1, 0);
            else begin
               ent = sb.pop_front();
               chk("rnd_data", {co32, ovf32, o32}, ent.exp);
               if (ent.st == stalls) chk("rnd_latency", cyc - ent.cyc, 4);
            end
         end
         if (v32_i && ro32) begin
            bprime = b32 ^ {32{s32}};
            sum    = {1'b0, a32} + {1'b0, bprime} + 33'(c32 ^ s32);
            ovf    = (a32[31] == bprime[31]) && (sum[31] != a32[31]);
            sb.push_back('{exp: {sum[32], ovf, sum[31:0]}, cyc: cyc, st: stalls});
         end
      end
      v32_i = 0; r32_i = 1;
      for (int d = 0; d < 20; d++) begin
         @(negedge clk);
         if (vo32 && sb.size() > 0) begin
            ent = sb.pop_front();
            chk("rnd_drain", {co32, ovf32, o32}, ent.exp);
         end
      end
      chk("rnd_sb_empty", sb.size(), 0);

      run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "deg_wrap");
      run16(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, "deg_sub");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
